// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a simple-dual-port RAM (Mem16/32/64 family).
// Write and read channels are arbitrated independently, round-robin, and read
// data is routed back to its requester using a tag pipeline that matches the
// RAM read latency.
// Optional feature macro: MEM_ARB_RAW_STALL_EN holds back a read whose address
// matches the write granted in the same cycle, so that the read returns post-write data.
module mem_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 9,
  parameter int RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid_a,
  input  logic              wr_valid_b,
  output logic              wr_ready_a,
  output logic              wr_ready_b,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              rd_valid_a,
  input  logic              rd_valid_b,
  output logic              rd_ready_a,
  output logic              rd_ready_b,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_rdaddress,
  input  logic [DATA_W-1:0] mem_q
);

  // Round-robin state: 1 means B won the last grant on that channel, so A wins a tie.
  logic wr_last_b;
  logic rd_last_b;

  logic wr_gnt_a, wr_gnt_b;
  logic rd_gnt_a, rd_gnt_b;
  logic rd_elig_a, rd_elig_b;
`ifdef MEM_ARB_RAW_STALL_EN
  logic [ADDR_W-1:0] wr_addr_win;
  logic              wr_any;
`endif

  // Tag pipeline: stage k holds the read accepted k+1 edges ago; id 1 = requester B.
  logic [RD_LATENCY:0] tag_vld_p;
  logic [RD_LATENCY:0] tag_id_p;

  // Grant decode: combinational in the valids and the round-robin pointers.
  always_comb begin
    wr_gnt_a = !reset && wr_valid_a && (!wr_valid_b || wr_last_b);
    wr_gnt_b = !reset && wr_valid_b && (!wr_valid_a || !wr_last_b);
`ifdef MEM_ARB_RAW_STALL_EN
    wr_any      = wr_gnt_a || wr_gnt_b;
    wr_addr_win = wr_gnt_b ? wr_addr_b : wr_addr_a;
    rd_elig_a   = rd_valid_a && !(wr_any && (rd_addr_a == wr_addr_win));
    rd_elig_b   = rd_valid_b && !(wr_any && (rd_addr_b == wr_addr_win));
`else
    rd_elig_a   = rd_valid_a;
    rd_elig_b   = rd_valid_b;
`endif
    rd_gnt_a = !reset && rd_elig_a && (!rd_elig_b || rd_last_b);
    rd_gnt_b = !reset && rd_elig_b && (!rd_elig_a || !rd_last_b);
    wr_ready_a = wr_gnt_a;
    wr_ready_b = wr_gnt_b;
    rd_ready_a = rd_gnt_a;
    rd_ready_b = rd_gnt_b;
  end

  // Pointer update: only a grant moves a pointer; idle cycles and stalls leave it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_last_b <= 1'b1;
      rd_last_b <= 1'b1;
    end else begin
      if (wr_gnt_a || wr_gnt_b) wr_last_b <= wr_gnt_b;
      if (rd_gnt_a || rd_gnt_b) rd_last_b <= rd_gnt_b;
    end
  end

  // Stage p0: register the winning write toward the RAM; data/address hold when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_wren      <= 1'b0;
      mem_data      <= '0;
      mem_wraddress <= '0;
    end else begin
      mem_wren <= wr_gnt_a || wr_gnt_b;
      if (wr_gnt_a) begin
        mem_data      <= wr_data_a;
        mem_wraddress <= wr_addr_a;
      end else if (wr_gnt_b) begin
        mem_data      <= wr_data_b;
        mem_wraddress <= wr_addr_b;
      end
    end
  end

  // Stage p0: register the winning read address; it holds until the next read grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_rdaddress <= '0;
    end else if (rd_gnt_a) begin
      mem_rdaddress <= rd_addr_a;
    end else if (rd_gnt_b) begin
      mem_rdaddress <= rd_addr_b;
    end
  end

  // Tag shift register tracking in-flight reads; reset drops everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld_p <= '0;
      tag_id_p  <= '0;
    end else begin
      tag_vld_p <= {tag_vld_p[RD_LATENCY-1:0], rd_gnt_a || rd_gnt_b};
      tag_id_p  <= {tag_id_p[RD_LATENCY-1:0], rd_gnt_b};
    end
  end

  // Return stage: capture RAM output for the tagged requester and strobe its rvalid.
  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= tag_vld_p[RD_LATENCY] && !tag_id_p[RD_LATENCY];
      rvalid_b <= tag_vld_p[RD_LATENCY] &&  tag_id_p[RD_LATENCY];
      if (tag_vld_p[RD_LATENCY] && !tag_id_p[RD_LATENCY]) rdata_a <= mem_q;
      if (tag_vld_p[RD_LATENCY] &&  tag_id_p[RD_LATENCY]) rdata_b <= mem_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a RAM model with RD_LATENCY pipeline behind
// the arbiter, directed stimulus, and a scoreboard monitor for read returns.
module tb_mem_port_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int L      = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid_a = 1'b0, wr_valid_b = 1'b0;
  logic              wr_ready_a, wr_ready_b;
  logic [ADDR_W-1:0] wr_addr_a = '0, wr_addr_b = '0;
  logic [DATA_W-1:0] wr_data_a = '0, wr_data_b = '0;
  logic              rd_valid_a = 1'b0, rd_valid_b = 1'b0;
  logic              rd_ready_a, rd_ready_b;
  logic [ADDR_W-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              rvalid_a, rvalid_b;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_wraddress;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_rdaddress;
  logic [DATA_W-1:0] mem_q;

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .wr_valid_a(wr_valid_a), .wr_valid_b(wr_valid_b),
    .wr_ready_a(wr_ready_a), .wr_ready_b(wr_ready_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
    .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .mem_data(mem_data), .mem_wraddress(mem_wraddress), .mem_wren(mem_wren),
    .mem_rdaddress(mem_rdaddress), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Edge counter: value seen at a negedge equals the number of posedges so far.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM model: write on wren, read through an L-deep pipeline (old data on same-address collision).
  logic [DATA_W-1:0] ram [512];
  logic [DATA_W-1:0] qp [L];
  always @(posedge clock) begin
    if (mem_wren) ram[mem_wraddress] <= mem_data;
    qp[0] <= ram[mem_rdaddress];
    for (int i = 1; i < L; i++) qp[i] <= qp[i-1];
  end
  assign mem_q = qp[L-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  // Monitor: pops the expected response whenever a read strobe appears.
  always @(negedge clock) begin
    exp_t e;
    if (rvalid_a) begin
      if (qa.size() == 0) chk("rvalid_a_unexpected", 1, 0);
      else begin
        e = qa.pop_front();
        chk("rdata_a", rdata_a, e.data);
        chk("rvalid_a_cycle", cyc, e.due);
      end
    end
    if (rvalid_b) begin
      if (qb.size() == 0) chk("rvalid_b_unexpected", 1, 0);
      else begin
        e = qb.pop_front();
        chk("rdata_b", rdata_b, e.data);
        chk("rvalid_b_cycle", cyc, e.due);
      end
    end
  end

  // One clock: check readies for the inputs just driven, queue expected reads, advance to next negedge.
  task automatic step(input string nm, input logic ewa, input logic ewb,
                      input logic era, input logic erb,
                      input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db,
                      input logic push);
    exp_t e;
    #1;
    chk({nm, "_wr_ready_a"}, wr_ready_a, ewa);
    chk({nm, "_wr_ready_b"}, wr_ready_b, ewb);
    chk({nm, "_rd_ready_a"}, rd_ready_a, era);
    chk({nm, "_rd_ready_b"}, rd_ready_b, erb);
    if (push && era) begin e.data = da; e.due = cyc + L + 2; qa.push_back(e); end
    if (push && erb) begin e.data = db; e.due = cyc + L + 2; qb.push_back(e); end
    @(negedge clock);
  endtask

  task automatic idle();
    wr_valid_a = 1'b0; wr_valid_b = 1'b0; rd_valid_a = 1'b0; rd_valid_b = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("idle_mem_wren", mem_wren, 0);
      chk("idle_outputs", |{wr_ready_a, wr_ready_b, rd_ready_a, rd_ready_b, rvalid_a, rvalid_b,
                            rdata_a, rdata_b, mem_data, mem_wraddress, mem_rdaddress}, 0);
    end

    // 2: simultaneous writes, A first then B
    wr_valid_a = 1; wr_addr_a = 0; wr_data_a = 16'h0234;
    wr_valid_b = 1; wr_addr_b = 1; wr_data_b = 16'h1234;
    step("t2_c0", 1, 0, 0, 0, 0, 0, 0);
    chk("t2_c0_wren", mem_wren, 1);
    chk("t2_c0_waddr", mem_wraddress, 0);
    chk("t2_c0_wdata", mem_data, 16'h0234);
    wr_valid_a = 0;
    step("t2_c1", 0, 1, 0, 0, 0, 0, 0);
    chk("t2_c1_wren", mem_wren, 1);
    chk("t2_c1_waddr", mem_wraddress, 1);
    chk("t2_c1_wdata", mem_data, 16'h1234);
    wr_valid_b = 0;
    wr_valid_a = 1; wr_addr_a = 2; wr_data_a = 16'h2234;
    step("t2_c2", 1, 0, 0, 0, 0, 0, 0);
    wr_addr_a = 5; wr_data_a = 16'h5555;
    step("t2_c3", 1, 0, 0, 0, 0, 0, 0);
    idle();
    step("t2_idle", 0, 0, 0, 0, 0, 0, 0);
    chk("t2_idle_wren", mem_wren, 0);
    chk("t2_hold_wdata", mem_data, 16'h5555);
    chk("t2_hold_waddr", mem_wraddress, 5);

    // 3: continuous reads from both, grants alternate starting with A
    rd_valid_a = 1; rd_addr_a = 0;
    rd_valid_b = 1; rd_addr_b = 1;
    for (int i = 0; i < 6; i++)
      step("t3_rd", 0, 0, (i % 2) == 0, (i % 2) == 1, 16'h0234, 16'h1234, 1);
    idle();
    for (int i = 0; i < L + 3; i++) step("t3_drain", 0, 0, 0, 0, 0, 0, 0);
    chk("t3_qa_empty", qa.size(), 0);
    chk("t3_qb_empty", qb.size(), 0);

    // 4: read then reset one clock later drops the read
    rd_valid_a = 1; rd_addr_a = 2;
    step("t4_rd", 0, 0, 1, 0, 0, 0, 0);
    chk("t4_rdaddr", mem_rdaddress, 2);
    idle();
    reset = 1;
    step("t4_rst0", 0, 0, 0, 0, 0, 0, 0);
    step("t4_rst1", 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    chk("t4_rdaddr_rst", mem_rdaddress, 0);
    for (int i = 0; i < L + 3; i++) begin
      step("t4_quiet", 0, 0, 0, 0, 0, 0, 0);
      chk("t4_no_rvalid_a", rvalid_a, 0);
    end
    rd_valid_a = 1; rd_addr_a = 2;
    step("t4_rd2", 0, 0, 1, 0, 16'h2234, 0, 1);
    idle();
    for (int i = 0; i < L + 3; i++) step("t4_drain", 0, 0, 0, 0, 0, 0, 0);
    chk("t4_qa_empty", qa.size(), 0);

    // 5/6: A writes addr 5 while B reads addr 5
    wr_valid_a = 1; wr_addr_a = 5; wr_data_a = 16'hBEEF;
    rd_valid_b = 1; rd_addr_b = 5;
`ifdef MEM_ARB_RAW_STALL_EN
    step("t5_conflict", 1, 0, 0, 0, 0, 0, 0);
    wr_valid_a = 0;
    step("t5_retry", 0, 0, 0, 1, 0, 16'hBEEF, 1);
`else
    step("t6_same_cycle", 1, 0, 0, 1, 0, 16'h5555, 1);
    wr_valid_a = 0;
`endif
    idle();
    step("t56_idle", 0, 0, 0, 0, 0, 0, 0);
    rd_valid_b = 1; rd_addr_b = 5;
    step("t56_reread", 0, 0, 0, 1, 0, 16'hBEEF, 1);
    idle();
    for (int i = 0; i < L + 4; i++) step("t56_drain", 0, 0, 0, 0, 0, 0, 0);
    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
